// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-first bypass and a per-register
// pending-load scoreboard (busy bits) for stall control.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            wrAddr,
    input  logic [DATA_W-1:0]            wrData,
    input  logic [RD_PORTS*ADDR_W-1:0]   rdAddr,
    output logic [RD_PORTS*DATA_W-1:0]   rdData,
    output logic [RD_PORTS-1:0]          rdBusy,
    input  logic                         reserve,
    input  logic [ADDR_W-1:0]            resAddr,
    input  logic                         flush,
    output logic [DEPTH-1:0]             busyVec,
    output logic [ADDR_W:0]              busyCount
);

    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic [DATA_W-1:0]          mem_d [DEPTH];
    logic [DEPTH-1:0]           busy_q, busy_d;
    logic [ADDR_W:0]            cnt_q, cnt_d;
    logic [RD_PORTS*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [RD_PORTS-1:0]        rd_busy_q, rd_busy_d;
    logic                       wr_en, res_en;

    assign wr_en  = write   && !((ZERO_REG != 0) && (wrAddr == '0));
    assign res_en = reserve && !((ZERO_REG != 0) && (resAddr == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wrAddr] = wrData;

        // Reserve is applied after the write clear: a newer producer wins.
        busy_d = busy_q;
        if (wr_en)  busy_d[wrAddr]  = 1'b0;
        if (res_en) busy_d[resAddr] = 1'b1;
        if (flush)  busy_d = '0;

        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end

        // Reads see next-state contents, giving the write-first bypass.
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            if ((ZERO_REG != 0) && (rdAddr[k*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_d[k*DATA_W +: DATA_W] = '0;
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] = mem_d[rdAddr[k*ADDR_W +: ADDR_W]];
            end
            rd_busy_d[k] = busy_d[rdAddr[k*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rdData    = rd_data_q;
    assign rdBusy    = rd_busy_q;
    assign busyVec   = busy_q;
    assign busyCount = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset and 4-port
// corner cases, then random traffic against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  wrAddr = '0;
    logic [19:0] wrData = '0;
    logic [7:0]  rdAddr = '0;
    logic [39:0] rdData;
    logic [1:0]  rdBusy;
    logic        reserve = 1'b0;
    logic [3:0]  resAddr = '0;
    logic        flush = 1'b0;
    logic [15:0] busyVec;
    logic [4:0]  busyCount;

    logic         w4_write = 1'b0;
    logic [3:0]   w4_wrAddr = '0;
    logic [31:0]  w4_wrData = '0;
    logic [15:0]  w4_rdAddr = '0;
    logic [127:0] w4_rdData;
    logic [3:0]   w4_rdBusy;
    logic [15:0]  w4_busyVec;
    logic [4:0]   w4_busyCount;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy), .reserve(reserve),
        .resAddr(resAddr), .flush(flush), .busyVec(busyVec), .busyCount(busyCount)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .RD_PORTS(4), .ZERO_REG(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .write(w4_write), .wrAddr(w4_wrAddr),
        .wrData(w4_wrData), .rdAddr(w4_rdAddr), .rdData(w4_rdData), .rdBusy(w4_rdBusy),
        .reserve(1'b0), .resAddr(4'd0), .flush(1'b0), .busyVec(w4_busyVec),
        .busyCount(w4_busyCount)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays updated by the architectural rules.
    logic [19:0] m_mem [16];
    logic        m_busy [16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_step(input logic w, input logic [3:0] wa, input logic [19:0] wd,
                          input logic r, input logic [3:0] ra, input logic f);
        if (w && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (r && ra != 0) m_busy[ra] = 1'b1;
        if (f) for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    endtask

    function automatic logic [15:0] m_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [4:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
        return 5'(n);
    endfunction

    task automatic cycle(input logic w, input logic [3:0] wa, input logic [19:0] wd,
                         input logic r, input logic [3:0] ra, input logic f,
                         input logic [3:0] a0, input logic [3:0] a1);
        write = w; wrAddr = wa; wrData = wd;
        reserve = r; resAddr = ra; flush = f;
        rdAddr = {a1, a0};
        @(posedge clk);
        #1;
        m_step(w, wa, wd, r, ra, f);
        write = 1'b0; reserve = 1'b0; flush = 1'b0;
    endtask

    typedef struct {
        logic w; logic [3:0] wa; logic [19:0] wd;
        logic r; logic [3:0] ra; logic f;
        logic [3:0] a0; logic [3:0] a1;
        logic [19:0] d0; logic [19:0] d1;
        logic b0; logic b1;
        logic [15:0] vec; logic [4:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic w, logic [3:0] wa, logic [19:0] wd, logic r,
                                logic [3:0] ra, logic f, logic [3:0] a0, logic [3:0] a1,
                                logic [19:0] d0, logic [19:0] d1, logic b0, logic b1,
                                logic [15:0] vec, logic [4:0] cnt);
        vec_t t;
        t.w = w; t.wa = wa; t.wd = wd; t.r = r; t.ra = ra; t.f = f;
        t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.b0 = b0; t.b1 = b1;
        t.vec = vec; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl [14];

    initial begin
        logic [31:0] v4 [5];
        logic        rw, rr, rf;
        logic [3:0]  rwa, rra, ra0, ra1;
        logic [19:0] rwd;

        //              w  wa     wd       r  ra     f  a0     a1     d0       d1       b0 b1 vec      cnt
        tbl[0]  = mk(0, 4'd0,  20'h0,     0, 4'd0,  0, 4'd3,  4'd15, 20'h0,     20'h0,     0, 0, 16'h0000, 0);
        tbl[1]  = mk(1, 4'd5,  20'hABCDE, 0, 4'd0,  0, 4'd5,  4'd3,  20'hABCDE, 20'h0,     0, 0, 16'h0000, 0);
        tbl[2]  = mk(0, 4'd0,  20'h0,     0, 4'd0,  0, 4'd5,  4'd5,  20'hABCDE, 20'hABCDE, 0, 0, 16'h0000, 0);
        tbl[3]  = mk(0, 4'd0,  20'h0,     1, 4'd7,  0, 4'd7,  4'd5,  20'h0,     20'hABCDE, 1, 0, 16'h0080, 1);
        tbl[4]  = mk(0, 4'd0,  20'h0,     0, 4'd0,  0, 4'd7,  4'd7,  20'h0,     20'h0,     1, 1, 16'h0080, 1);
        tbl[5]  = mk(1, 4'd7,  20'h12345, 0, 4'd0,  0, 4'd7,  4'd5,  20'h12345, 20'hABCDE, 0, 0, 16'h0000, 0);
        tbl[6]  = mk(1, 4'd9,  20'h00001, 1, 4'd9,  0, 4'd9,  4'd7,  20'h00001, 20'h12345, 1, 0, 16'h0200, 1);
        tbl[7]  = mk(1, 4'd4,  20'h55555, 1, 4'd2,  0, 4'd2,  4'd4,  20'h0,     20'h55555, 1, 0, 16'h0204, 2);
        tbl[8]  = mk(0, 4'd0,  20'h0,     1, 4'd1,  0, 4'd1,  4'd2,  20'h0,     20'h0,     1, 1, 16'h0206, 3);
        tbl[9]  = mk(0, 4'd0,  20'h0,     1, 4'd3,  0, 4'd3,  4'd9,  20'h0,     20'h00001, 1, 1, 16'h020E, 4);
        tbl[10] = mk(0, 4'd0,  20'h0,     1, 4'd4,  1, 4'd4,  4'd3,  20'h55555, 20'h0,     0, 0, 16'h0000, 0);
        tbl[11] = mk(1, 4'd0,  20'hFFFFF, 1, 4'd0,  0, 4'd0,  4'd0,  20'h0,     20'h0,     0, 0, 16'h0000, 0);
        tbl[12] = mk(0, 4'd0,  20'h0,     1, 4'd10, 0, 4'd10, 4'd10, 20'h0,     20'h0,     1, 1, 16'h0400, 1);
        tbl[13] = mk(1, 4'd10, 20'h0BEEF, 0, 4'd0,  1, 4'd10, 4'd0,  20'h0BEEF, 20'h0,     0, 0, 16'h0000, 0);

        m_reset();
        #3;
        chk("reset_busyVec", 64'(busyVec), 64'h0);
        chk("reset_busyCount", 64'(busyCount), 64'h0);
        chk("reset_rdData", 64'(rdData), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra, tbl[i].f,
                  tbl[i].a0, tbl[i].a1);
            chk($sformatf("row%0d_d0", i), 64'(rdData[19:0]), 64'(tbl[i].d0));
            chk($sformatf("row%0d_d1", i), 64'(rdData[39:20]), 64'(tbl[i].d1));
            chk($sformatf("row%0d_b0", i), 64'(rdBusy[0]), 64'(tbl[i].b0));
            chk($sformatf("row%0d_b1", i), 64'(rdBusy[1]), 64'(tbl[i].b1));
            chk($sformatf("row%0d_vec", i), 64'(busyVec), 64'(tbl[i].vec));
            chk($sformatf("row%0d_cnt", i), 64'(busyCount), 64'(tbl[i].cnt));
        end

        // Asynchronous reset in the middle of a cycle with a pending reservation.
        cycle(0, 4'd0, 20'h0, 1, 4'd6, 0, 4'd5, 4'd6);
        chk("prereset_busy6", 64'(busyVec[6]), 64'h1);
        chk("prereset_data", 64'(rdData[19:0]), 64'hABCDE);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busyVec", 64'(busyVec), 64'h0);
        chk("midreset_rdData", 64'(rdData), 64'h0);
        chk("midreset_busyCount", 64'(busyCount), 64'h0);
        chk("midreset_rdBusy", 64'(rdBusy), 64'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Four-port, 32-bit variant: each port returns its own register.
        for (int i = 1; i <= 4; i++) begin
            v4[i] = $urandom;
            w4_write = 1'b1; w4_wrAddr = 4'(i); w4_wrData = v4[i];
            @(posedge clk);
            #1;
        end
        w4_write = 1'b0;
        w4_rdAddr = {4'd4, 4'd3, 4'd2, 4'd1};
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("port4_%0d", k), 64'(w4_rdData[k*32 +: 32]), 64'(v4[k+1]));
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rw  = 1'($urandom % 2);
            rwa = 4'($urandom);
            rwd = 20'($urandom);
            rr  = ($urandom % 3) == 0;
            rra = (($urandom % 4) == 0) ? rwa : 4'($urandom);
            rf  = ($urandom % 16) == 0;
            ra0 = (($urandom % 3) == 0) ? rwa : 4'($urandom);
            ra1 = (($urandom % 3) == 0) ? rra : 4'($urandom);
            cycle(rw, rwa, rwd, rr, rra, rf, ra0, ra1);
            chk("rnd_d0", 64'(rdData[19:0]), 64'(m_mem[ra0]));
            chk("rnd_d1", 64'(rdData[39:20]), 64'(m_mem[ra1]));
            chk("rnd_b0", 64'(rdBusy[0]), 64'(m_busy[ra0]));
            chk("rnd_b1", 64'(rdBusy[1]), 64'(m_busy[ra1]));
            chk("rnd_vec", 64'(busyVec), 64'(m_vec()));
            chk("rnd_cnt", 64'(busyCount), 64'(m_cnt()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
